// File: rtl/pb_debouncer_fsm.sv
// Push-button debouncer: a four-state FSM accepts a level after DEBOUNCE_CYCLES equal samples.
// Define PB_DEBOUNCER_SYNC_EN to put a two-flop synchronizer in front of the FSM (+2 cycles latency).
module pb_debouncer_fsm #(
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  output logic PB_pressed_status,
  output logic PB_pressed_pulse,
  output logic PB_released_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic            status_q;
  logic            press_pulse_q;
  logic            release_pulse_q;
  logic            pb_s;

`ifdef PB_DEBOUNCER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], PB};
  end

  assign pb_s = sync_q[1];
`else
  assign pb_s = PB;
`endif

  // Saturating increment: the counter can never wrap back into the wait window.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      status_q        <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pb_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pb_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q       <= PRESSED;
            cnt_q         <= '0;
            status_q      <= 1'b1;
            press_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!pb_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= CW'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (pb_s) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            status_q        <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          status_q <= 1'b0;
        end
      endcase
    end
  end

  assign PB_pressed_status = status_q;
  assign PB_pressed_pulse  = press_pulse_q;
  assign PB_released_pulse = release_pulse_q;

  a_pulse_excl: assert property (@(posedge clk) disable iff (!rst)
    !(press_pulse_q && release_pulse_q));

endmodule

// File: tb/tb_pb_debouncer_fsm.sv
// Scoreboard bench for pb_debouncer_fsm: a run-length reference model pushes expected outputs per edge.
module tb_pb_debouncer_fsm;
  localparam int D = 10;
`ifdef PB_DEBOUNCER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic PB  = 1'b0;
  logic PB_pressed_status, PB_pressed_pulse, PB_released_pulse;

  int n_cmp = 0;
  int n_mis = 0;

  logic [2:0] sb[$];
  logic       m_acc;
  int         m_run;
  logic       m_s1, m_s2;

  pb_debouncer_fsm #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .PB(PB),
    .PB_pressed_status(PB_pressed_status),
    .PB_pressed_pulse(PB_pressed_pulse),
    .PB_released_pulse(PB_released_pulse)
  );

  always #5 clk = ~clk;

  // Reference: count consecutive samples that disagree with the accepted level.
  function automatic void model_step();
    logic smp, pp, rp;
    pp = 1'b0; rp = 1'b0;
    if (!rst) begin
      m_acc = 1'b0; m_run = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      if (LAT == 2) begin smp = m_s2; m_s2 = m_s1; m_s1 = PB; end
      else smp = PB;
      if (smp != m_acc) begin
        m_run++;
        if (m_run == D) begin
          m_acc = smp; m_run = 0;
          if (smp) pp = 1'b1; else rp = 1'b1;
        end
      end else m_run = 0;
    end
    sb.push_back({m_acc, pp, rp});
  endfunction

  // Drive one sample for the upcoming edge and record what the DUT must show after it.
  task automatic drive(input logic v, input logic r);
    PB = v; rst = r;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    #1;
    n_cmp++;
    if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== 3'b000) begin
      n_mis++; $display("FAIL reset_init got=%b want=000", {PB_pressed_status, PB_pressed_pulse, PB_released_pulse});
    end
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      drive(i[0] ? 1'b0 : 1'b1, 1'b0);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
    end
    drive(1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    logic stim[$];
    int seen;
    stim = {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0};
    for (int i = 0; i < 12; i++) stim.push_back(1'b0);
    sb.delete(); seen = 0;
    foreach (stim[i]) begin
      drive(stim[i], 1'b1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL glitch cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      seen += int'(PB_pressed_status | PB_pressed_pulse | PB_released_pulse);
    end
    n_cmp++;
    if (seen != 0) begin n_mis++; $display("FAIL glitch_quiet active_cycles=%0d want=0", seen); end
  endtask

  task automatic test_press_release();
    logic [2:0] exp;
    int np, nr, rise, fall;
    sb.delete(); np = 0; nr = 0; rise = -1; fall = -1;
    for (int i = 0; i < 40; i++) begin
      drive(i < 20, 1'b1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL press_release cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      np += int'(PB_pressed_pulse); nr += int'(PB_released_pulse);
      if (PB_pressed_status && rise < 0) rise = i;
      if (!PB_pressed_status && rise >= 0 && fall < 0) fall = i;
    end
    n_cmp++;
    if (rise != D - 1 + LAT) begin n_mis++; $display("FAIL press_latency got=%0d want=%0d", rise, D - 1 + LAT); end
    n_cmp++;
    if (fall != 20 + D - 1 + LAT) begin n_mis++; $display("FAIL release_latency got=%0d want=%0d", fall, 20 + D - 1 + LAT); end
    n_cmp++;
    if (np != 1 || nr != 1) begin n_mis++; $display("FAIL pulse_count pressed=%0d released=%0d want=1/1", np, nr); end
  endtask

  task automatic test_release_glitch();
    logic [2:0] exp;
    int nr, drop;
    sb.delete(); nr = 0; drop = 0;
    for (int i = 0; i < 45; i++) begin
      drive((i < 14) || (i >= 18 && i < 26), 1'b1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL release_glitch cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      if (i >= 12 && i < 26 && !PB_pressed_status) drop++;
      if (i < 26) nr += int'(PB_released_pulse);
    end
    n_cmp++;
    if (drop != 0 || nr != 0) begin n_mis++; $display("FAIL release_glitch_hold drops=%0d rel_pulses=%0d want=0/0", drop, nr); end
  endtask

  task automatic test_reset_abort();
    logic [2:0] exp;
    int at, early;
    sb.delete(); at = -1; early = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL abort_pre cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      early += int'(PB_pressed_pulse);
    end
    drive(1'b1, 1'b0);
    exp = sb.pop_front(); n_cmp++;
    if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
      n_mis++; $display("FAIL abort_rst got=%b want=%b", {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL abort_post cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      if (PB_pressed_pulse && at < 0) at = i;
    end
    n_cmp++;
    if (early != 0 || at != D - 1 + LAT) begin
      n_mis++; $display("FAIL abort_timing early=%0d pulse_at=%0d want=0/%0d", early, at, D - 1 + LAT);
    end
    for (int i = 0; i < D + LAT + 2; i++) begin
      drive(1'b0, 1'b1);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset_in_pulse();
    logic [2:0] exp;
    int guard, nr;
    sb.delete(); guard = 0; nr = 0;
    while (!PB_pressed_pulse && guard < 40) begin
      drive(1'b1, 1'b1);
      void'(sb.pop_front());
      guard++;
    end
    n_cmp++;
    if (!PB_pressed_pulse) begin n_mis++; $display("FAIL pulse_wait timeout got=0 want=1"); end
    rst = 1'b0; #1;
    n_cmp++;
    if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== 3'b000) begin
      n_mis++; $display("FAIL async_reset got=%b want=000", {PB_pressed_status, PB_pressed_pulse, PB_released_pulse});
    end
    @(negedge clk);
    sb.delete();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, i > 1);
      exp = sb.pop_front(); n_cmp++;
      if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
        n_mis++; $display("FAIL post_pulse_reset cyc=%0d got=%b want=%b", i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
      end
      nr += int'(PB_released_pulse);
    end
    n_cmp++;
    if (nr != 0) begin n_mis++; $display("FAIL reset_no_release got=%0d want=0", nr); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    int np, nr;
    sb.delete(); np = 0; nr = 0;
    // Exactly D-1 high (reject), then D high (accept), D-1 low (reject), D low (accept), repeated.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4 * D + 2; i++) begin
        if (i < D - 1)              PB = 1'b1;
        else if (i == D - 1)        PB = 1'b0;
        else if (i < 2 * D)         PB = 1'b1;
        else if (i < 3 * D - 1)     PB = 1'b0;
        else if (i == 3 * D - 1)    PB = 1'b1;
        else                        PB = 1'b0;
        drive(PB, 1'b1);
        exp = sb.pop_front(); n_cmp++;
        if ({PB_pressed_status, PB_pressed_pulse, PB_released_pulse} !== exp) begin
          n_mis++; $display("FAIL back_to_back r=%0d cyc=%0d got=%b want=%b", r, i, {PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, exp);
        end
        np += int'(PB_pressed_pulse); nr += int'(PB_released_pulse);
      end
      for (int i = 0; i < D + LAT; i++) begin
        drive(1'b0, 1'b1);
        void'(sb.pop_front());
      end
    end
    n_cmp++;
    if (np != 2 || nr != 2) begin n_mis++; $display("FAIL b2b_count pressed=%0d released=%0d want=2/2", np, nr); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_release_glitch();
    test_reset_abort();
    test_reset_in_pulse();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
